// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S receiver: FSM states, defaults, short-word alignment.
// Purely combinational definitions; no latency, no backpressure.
package i2s_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_TIMEOUT = 1024;
    localparam logic [5:0] K_MAX = 6'd63;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_e;

    // Left shift that moves a short slot's bits up to the MSB end of the word.
    function automatic logic [6:0] pad_bits(input logic [6:0] data_w, input logic [6:0] slot_len);
        return data_w - slot_len;
    endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// Synchronizes bck/lrck/data into clk and flags each BCK rising edge, with ws/data aligned to it.
// Latency SYNC_STAGES+1 clk from pin to rise_o; no backpressure (free-running).
module i2s_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic bck_i,
    input  logic lrck_i,
    input  logic data_i,
    output logic rise_o,
    output logic ws_o,
    output logic data_o
);

    logic [SYNC_STAGES-1:0] bck_sync_q;
    logic [SYNC_STAGES-1:0] ws_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   bck_dly_q;
    logic                   rise_q;
    logic                   ws_q;
    logic                   data_q;

    // Outputs are registered so ws/data stay paired with the rise pulse they were sampled with.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bck_sync_q <= '0;
            ws_sync_q  <= '0;
            dat_sync_q <= '0;
            bck_dly_q  <= 1'b0;
            rise_q     <= 1'b0;
            ws_q       <= 1'b0;
            data_q     <= 1'b0;
        end else begin
            bck_sync_q <= {bck_sync_q[SYNC_STAGES-2:0], bck_i};
            ws_sync_q  <= {ws_sync_q[SYNC_STAGES-2:0], lrck_i};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], data_i};
            bck_dly_q  <= bck_sync_q[SYNC_STAGES-1];
            rise_q     <= bck_sync_q[SYNC_STAGES-1] & ~bck_dly_q;
            ws_q       <= ws_sync_q[SYNC_STAGES-1];
            data_q     <= dat_sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = rise_q;
    assign ws_o   = ws_q;
    assign data_o = data_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: recovers left/right slots and presents stereo pairs on a valid/ready holding register.
// sample_valid rises SYNC_STAGES+2 clk after the closing BCK edge; a full register drops new pairs and flags overrun.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int   DATA_W      = DEF_DATA_W,
    parameter logic LEFT_WS     = 1'b0,
    parameter int   TIMEOUT     = DEF_TIMEOUT,
    parameter int   SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i2s_bck,
    input  logic              i2s_lrck,
    input  logic              i2s_data,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              locked,
    output logic              overrun,
    output logic              short_slot,
    input  logic              err_clr
);

    localparam int              TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    logic rise;
    logic ws_s;
    logic data_s;

    i2s_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .bck_i  (i2s_bck),
        .lrck_i (i2s_lrck),
        .data_i (i2s_data),
        .rise_o (rise),
        .ws_o   (ws_s),
        .data_o (data_s)
    );

    state_e            state_q, state_d;
    logic              ws_prev_q, ws_prev_d;
    logic [5:0]        k_q, k_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] left_hold_q, left_hold_d;
    logic [DATA_W-1:0] sample_l_q, sample_l_d;
    logic [DATA_W-1:0] sample_r_q, sample_r_d;
    logic              valid_q, valid_d;
    logic              locked_q, locked_d;
    logic              overrun_q, overrun_d;
    logic              short_q, short_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    logic              ws_chg;
    logic              timeout;
    logic              in_word;
    logic [DATA_W-1:0] shreg_sh;
    logic [6:0]        slot_len;
    logic              is_short;
    logic [DATA_W-1:0] word;
    logic              lock_set;
    logic              left_latch;
    logic              pair_close;
    logic              load_pair;
    logic              short_set;

    // The bit sampled on a WS change still belongs to the slot being closed.
    always_comb begin
        ws_chg   = rise && (ws_s != ws_prev_q);
        timeout  = (to_cnt_q == TO_MAX) && !rise;
        in_word  = ({1'b0, k_q} < 7'(DATA_W));
        shreg_sh = in_word ? {shreg_q[DATA_W-2:0], data_s} : shreg_q;
        slot_len = {1'b0, k_q} + 7'd1;
        is_short = slot_len < 7'(DATA_W);
        word     = is_short ? (shreg_sh << pad_bits(7'(DATA_W), slot_len)) : shreg_sh;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = ST_SYNC;
        end else if (ws_chg) begin
            case (state_q)
                ST_SYNC:  state_d = (ws_s == LEFT_WS) ? ST_LEFT : ST_SYNC;
                ST_LEFT:  state_d = ST_RIGHT;
                ST_RIGHT: state_d = ST_LEFT;
                default:  state_d = ST_SYNC;
            endcase
        end
    end

    always_comb begin
        lock_set   = 1'b0;
        left_latch = 1'b0;
        pair_close = 1'b0;
        if (!timeout && ws_chg) begin
            case (state_q)
                ST_SYNC:  lock_set   = (ws_s == LEFT_WS);
                ST_LEFT:  left_latch = 1'b1;
                ST_RIGHT: pair_close = 1'b1;
                default:  lock_set   = 1'b0;
            endcase
        end
    end

    // Partial slots seen while hunting for alignment are not reported as short.
    always_comb begin
        load_pair = pair_close && (!valid_q || sample_ready);
        short_set = ws_chg && is_short && !timeout && (state_q != ST_SYNC);

        ws_prev_d   = rise ? ws_s : ws_prev_q;
        k_d         = k_q;
        shreg_d     = shreg_q;
        left_hold_d = left_hold_q;
        if (timeout) begin
            k_d         = '0;
            shreg_d     = '0;
            left_hold_d = '0;
        end else if (rise) begin
            if (ws_chg) begin
                k_d     = '0;
                shreg_d = '0;
            end else begin
                k_d     = (k_q == K_MAX) ? K_MAX : k_q + 6'd1;
                shreg_d = shreg_sh;
            end
            if (left_latch) begin
                left_hold_d = word;
            end
        end

        sample_l_d = load_pair ? left_hold_q : sample_l_q;
        sample_r_d = load_pair ? word : sample_r_q;
        if (load_pair) begin
            valid_d = 1'b1;
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        locked_d  = timeout ? 1'b0 : (lock_set ? 1'b1 : locked_q);
        overrun_d = err_clr ? 1'b0 : ((pair_close && !load_pair) ? 1'b1 : overrun_q);
        short_d   = err_clr ? 1'b0 : (short_set ? 1'b1 : short_q);

        if (rise) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_MAX) begin
            to_cnt_d = to_cnt_q;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_prev_q   <= 1'b0;
            k_q         <= '0;
            shreg_q     <= '0;
            left_hold_q <= '0;
            sample_l_q  <= '0;
            sample_r_q  <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            overrun_q   <= 1'b0;
            short_q     <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            ws_prev_q   <= ws_prev_d;
            k_q         <= k_d;
            shreg_q     <= shreg_d;
            left_hold_q <= left_hold_d;
            sample_l_q  <= sample_l_d;
            sample_r_q  <= sample_r_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            overrun_q   <= overrun_d;
            short_q     <= short_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign sample_valid = valid_q;
    assign locked       = locked_q;
    assign overrun      = overrun_q;
    assign short_slot   = short_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: serial I2S frames with BCK = clk/8, checked against hand-computed words.
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i2s_bck = 1'b0;
    logic        i2s_lrck = 1'b0;
    logic        i2s_data = 1'b0;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic        locked;
    logic        overrun;
    logic        short_slot;
    logic        err_clr = 1'b0;

    int   n_chk = 0;
    int   n_err = 0;
    logic pend = 1'b0;
    logic pulse_rdy = 1'b0;

    always #5 clk = ~clk;

    i2s_rx dut (
        .clk          (clk),
        .resetn       (resetn),
        .i2s_bck      (i2s_bck),
        .i2s_lrck     (i2s_lrck),
        .i2s_data     (i2s_data),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .locked       (locked),
        .overrun      (overrun),
        .short_slot   (short_slot),
        .err_clr      (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One BCK period: lines change while bck is low, receiver samples on the rising half.
    task automatic send_bit(input logic ws, input logic d);
        i2s_bck  = 1'b0;
        i2s_lrck = ws;
        i2s_data = d;
        repeat (4) @(negedge clk);
        i2s_bck = 1'b1;
        if (pulse_rdy) begin
            repeat (3) @(negedge clk);
            sample_ready = 1'b1;
            @(negedge clk);
            sample_ready = 1'b0;
        end else begin
            repeat (4) @(negedge clk);
        end
    endtask

    // Bit periods lo..hi of an nbits slot; data lags ws by one period as in I2S.
    task automatic send_bits(input logic ws, input logic [63:0] word, input int nbits,
                             input int lo, input int hi);
        for (int j = lo; j <= hi; j++) begin
            send_bit(ws, pend);
            pend = word[nbits-1-j];
        end
    endtask

    function automatic logic [63:0] w32(input logic [15:0] v);
        return {32'h0, v, 16'h0};
    endfunction

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_bits(1'b0, w32(l), 32, 0, 31);
        send_bits(1'b1, w32(r), 32, 0, 31);
    endtask

    task automatic junk_right(input int nbits, input int lo);
        logic [63:0] j;
        j = {$urandom, $urandom};
        send_bits(1'b1, j, nbits, lo, nbits - 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_l"},     32'(sample_l), 32'h0);
        chk({tag, "_r"},     32'(sample_r), 32'h0);
        chk({tag, "_valid"}, 32'(sample_valid), 32'h0);
        chk({tag, "_locked"}, 32'(locked), 32'h0);
        chk({tag, "_ovr"},   32'(overrun), 32'h0);
        chk({tag, "_short"}, 32'(short_slot), 32'h0);
    endtask

    task automatic check_pair(input string tag, input logic [15:0] l, input logic [15:0] r);
        chk({tag, "_valid"}, 32'(sample_valid), 32'h1);
        chk({tag, "_l"},     32'(sample_l), 32'(l));
        chk({tag, "_r"},     32'(sample_r), 32'(r));
    endtask

    initial begin
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("rst");

        // Basic frame, lock point and output latency.
        junk_right(32, 0);
        chk("t1_unlocked", 32'(locked), 32'h0);
        send_bits(1'b0, w32(16'h8001), 32, 0, 31);
        chk("t1_locked", 32'(locked), 32'h1);
        send_bits(1'b1, w32(16'h7FFE), 32, 0, 31);
        chk("t1_novalid", 32'(sample_valid), 32'h0);
        i2s_bck  = 1'b0;
        i2s_lrck = 1'b0;
        i2s_data = pend;
        repeat (4) @(negedge clk);
        i2s_bck = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_lat_pre", 32'(sample_valid), 32'h0);
        @(negedge clk);
        chk("t1_lat_post", 32'(sample_valid), 32'h1);
        repeat (40) @(negedge clk);
        check_pair("t1_held", 16'h8001, 16'h7FFE);
        chk("t1_short", 32'(short_slot), 32'h0);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        chk("t1_accepted", 32'(sample_valid), 32'h0);

        // Stream joins mid right slot.
        pulse_reset();
        junk_right(32, 20);
        send_bits(1'b0, w32(16'h0F0F), 32, 0, 31);
        chk("t2_locked", 32'(locked), 32'h1);
        send_bits(1'b1, w32(16'hF0F0), 32, 0, 31);
        chk("t2_novalid", 32'(sample_valid), 32'h0);
        send_bits(1'b0, 64'h0, 32, 0, 0);
        repeat (4) @(negedge clk);
        check_pair("t2", 16'h0F0F, 16'hF0F0);

        // Overrun, err_clr, and accept coinciding with a new pair load.
        pulse_reset();
        junk_right(32, 0);
        send_frame(16'h1111, 16'h2222);
        send_frame(16'h3333, 16'h4444);
        send_bits(1'b0, w32(16'h5555), 32, 0, 0);
        repeat (4) @(negedge clk);
        check_pair("t3_kept", 16'h1111, 16'h2222);
        chk("t3_ovr_set", 32'(overrun), 32'h1);
        pulse_err_clr();
        chk("t3_ovr_clr", 32'(overrun), 32'h0);
        send_bits(1'b0, w32(16'h5555), 32, 1, 31);
        send_bits(1'b1, w32(16'h6666), 32, 0, 31);
        pulse_rdy = 1'b1;
        send_bits(1'b0, 64'h0, 32, 0, 0);
        pulse_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check_pair("t3_swap", 16'h5555, 16'h6666);
        chk("t3_ovr_none", 32'(overrun), 32'h0);

        // 12-bit slots are left-aligned and flagged.
        pulse_reset();
        junk_right(12, 0);
        send_bits(1'b0, 64'hABC, 12, 0, 11);
        send_bits(1'b1, 64'hABC, 12, 0, 11);
        send_bits(1'b0, 64'h0, 12, 0, 0);
        repeat (4) @(negedge clk);
        check_pair("t4", 16'hABC0, 16'hABC0);
        chk("t4_short", 32'(short_slot), 32'h1);
        pulse_err_clr();
        chk("t4_short_clr", 32'(short_slot), 32'h0);

        // BCK stops: lock drops after TIMEOUT, held pair survives.
        repeat (980) @(negedge clk);
        chk("t5_still_locked", 32'(locked), 32'h1);
        repeat (120) @(negedge clk);
        chk("t5_unlocked", 32'(locked), 32'h0);
        check_pair("t5_kept", 16'hABC0, 16'hABC0);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        junk_right(32, 0);
        send_frame(16'h1234, 16'h5678);
        send_bits(1'b0, w32(16'hAAAA), 32, 0, 0);
        repeat (4) @(negedge clk);
        check_pair("t5_relock", 16'h1234, 16'h5678);
        chk("t5_locked", 32'(locked), 32'h1);

        // Reset mid right slot with a pair held.
        send_bits(1'b0, w32(16'hAAAA), 32, 1, 31);
        send_bits(1'b1, w32(16'h5555), 32, 0, 9);
        pulse_reset();
        check_reset("t6_rst");
        send_bits(1'b1, w32(16'h5555), 32, 10, 31);
        chk("t6_nolock", 32'(locked), 32'h0);
        send_frame(16'h9ABC, 16'hDEF0);
        send_bits(1'b0, 64'h0, 32, 0, 0);
        repeat (4) @(negedge clk);
        check_pair("t6", 16'h9ABC, 16'hDEF0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
